// File: rtl/mem_bank_arbiter.sv
// Two-port (CU / DBG) arbiter and access sequencer for a single shared memory bank.
// Round-robin between ports, dbg_halt masks CU from new grants, registered memory-side outputs.
module mem_bank_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          CLK100MHZ,
    input  logic          rst,

    input  logic          cu_req,
    input  logic          cu_we,
    input  logic [AW-1:0] cu_addr,
    input  logic [DW-1:0] cu_wdata,
    output logic          cu_ack,
    output logic [DW-1:0] cu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,

    input  logic          dbg_halt,

    output logic [AW-1:0] mb_addr,
    output logic [DW-1:0] mb_din,
    output logic          mb_read,
    output logic          mb_write,
    input  logic [DW-1:0] mb_data_out,

    output logic          owner,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t        cur_state;
    state_t        nxt_state;
    logic          last;
    logic          own;
    logic          we_lat;
    logic [1:0]    lat_cnt;

    logic          cu_eff;
    logic          grant;
    logic          grant_dbg;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration and next-state; on a tie the port not named by `last` wins.
    always_comb begin
        cu_eff    = cu_req & ~dbg_halt;
        grant     = 1'b0;
        grant_dbg = 1'b0;
        nxt_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (cu_eff || dbg_req) begin
                    grant     = 1'b1;
                    grant_dbg = dbg_req & (~cu_eff | ~last);
                    nxt_state = ISSUE;
                end
            end
            ISSUE:   nxt_state = we_lat ? DONE : WAIT;
            WAIT:    if (lat_cnt == 2'd0) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        sel_we    = grant_dbg ? dbg_we    : cu_we;
        sel_addr  = grant_dbg ? dbg_addr  : cu_addr;
        sel_wdata = grant_dbg ? dbg_wdata : cu_wdata;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // mb_addr / mb_din double as the latched request fields and hold between accesses.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            last     <= 1'b1;
            own      <= 1'b0;
            we_lat   <= 1'b0;
            mb_addr  <= '0;
            mb_din   <= '0;
            mb_read  <= 1'b0;
            mb_write <= 1'b0;
        end else begin
            mb_read  <= grant & ~sel_we;
            mb_write <= grant & sel_we;
            if (grant) begin
                last    <= grant_dbg;
                own     <= grant_dbg;
                we_lat  <= sel_we;
                mb_addr <= sel_addr;
                mb_din  <= sel_wdata;
            end
        end
    end

    // Read latency countdown and capture into the granted port's read-data register.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            lat_cnt   <= 2'd0;
            cu_rdata  <= '0;
            dbg_rdata <= '0;
        end else begin
            if (cur_state == ISSUE) begin
                lat_cnt <= LAT_INIT;
            end else if (cur_state == WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (cur_state == WAIT && lat_cnt == 2'd0) begin
                if (own) dbg_rdata <= mb_data_out;
                else     cu_rdata  <= mb_data_out;
            end
        end
    end

    assign cu_ack  = (cur_state == DONE) & ~own;
    assign dbg_ack = (cur_state == DONE) &  own;
    assign owner   = own;
    assign state   = cur_state;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Randomized self-checking bench for mem_bank_arbiter: a behavioural bank and reference model
// for RD_LAT=1, plus a second RD_LAT=4 instance with a hand-driven read data bus.
module tb_mem_bank_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cu_req = 0, cu_we = 0, dbg_req = 0, dbg_we = 0, dbg_halt = 0;
    logic [7:0]  cu_addr = '0, dbg_addr = '0;
    logic [15:0] cu_wdata = '0, dbg_wdata = '0;
    logic        cu_ack, dbg_ack, mb_read, mb_write, owner;
    logic [15:0] cu_rdata, dbg_rdata, mb_din;
    logic [7:0]  mb_addr;
    logic [1:0]  state;
    logic [15:0] mb_data_out = '0;

    logic        l4_cu_req = 0, l4_cu_we = 0, l4_dbg_req = 0, l4_dbg_we = 0, l4_dbg_halt = 0;
    logic [7:0]  l4_cu_addr = '0, l4_dbg_addr = '0;
    logic [15:0] l4_cu_wdata = '0, l4_dbg_wdata = '0, l4_mb_data_out = '0;
    logic        l4_cu_ack, l4_dbg_ack, l4_mb_read, l4_mb_write, l4_owner;
    logic [15:0] l4_cu_rdata, l4_dbg_rdata, l4_mb_din;
    logic [7:0]  l4_mb_addr;
    logic [1:0]  l4_state;

    mem_bank_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) dut (
        .CLK100MHZ(clk), .rst(rst),
        .cu_req(cu_req), .cu_we(cu_we), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
        .cu_ack(cu_ack), .cu_rdata(cu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_halt(dbg_halt),
        .mb_addr(mb_addr), .mb_din(mb_din), .mb_read(mb_read), .mb_write(mb_write),
        .mb_data_out(mb_data_out), .owner(owner), .state(state)
    );

    mem_bank_arbiter #(.AW(8), .DW(16), .RD_LAT(4)) dut4 (
        .CLK100MHZ(clk), .rst(rst),
        .cu_req(l4_cu_req), .cu_we(l4_cu_we), .cu_addr(l4_cu_addr), .cu_wdata(l4_cu_wdata),
        .cu_ack(l4_cu_ack), .cu_rdata(l4_cu_rdata),
        .dbg_req(l4_dbg_req), .dbg_we(l4_dbg_we), .dbg_addr(l4_dbg_addr), .dbg_wdata(l4_dbg_wdata),
        .dbg_ack(l4_dbg_ack), .dbg_rdata(l4_dbg_rdata), .dbg_halt(l4_dbg_halt),
        .mb_addr(l4_mb_addr), .mb_din(l4_mb_din), .mb_read(l4_mb_read), .mb_write(l4_mb_write),
        .mb_data_out(l4_mb_data_out), .owner(l4_owner), .state(l4_state)
    );

    int checks = 0;
    int errors = 0;

    // Initial bank contents; address 0x10 holds 0x1234.
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : ((16'(a) * 16'd977) ^ 16'hA5C3);
    endfunction

    // Behavioural RD_LAT=1 bank: data appears the cycle after the read strobe.
    logic [15:0] mem [256];
    bit          mem_wr [256];
    always @(posedge clk) begin
        if (mb_write) begin
            mem[mb_addr]    <= mb_din;
            mem_wr[mb_addr] <= 1'b1;
        end
        if (mb_read) mb_data_out <= mem_wr[mb_addr] ? mem[mb_addr] : init_val(mb_addr);
    end

    // Reference model: expected memory image, per-port held read data, round-robin pointer.
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rdata [2];
    bit          model_last;

    function automatic logic [15:0] ref_rd(input logic [7:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction on a port of the RD_LAT=1 instance and observe it (no checking here).
    task automatic run_txn(input bit port, input bit we, input logic [7:0] a, input logic [15:0] d,
                           output int ack_c, output int stb_c, output logic [7:0] s_addr,
                           output logic [15:0] s_din, output bit s_rd, output bit s_own,
                           output bit wrong_ack, output bit both_stb, output logic [15:0] rd);
        ack_c = -1; stb_c = -1; s_addr = '0; s_din = '0; s_rd = 0; s_own = 0;
        wrong_ack = 0; both_stb = 0; rd = '0;
        if (port) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
        else      begin cu_req  = 1; cu_we  = we; cu_addr  = a; cu_wdata  = d; end
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (mb_read && mb_write) both_stb = 1;
            if ((mb_read || mb_write) && stb_c < 0) begin
                stb_c = c; s_addr = mb_addr; s_din = mb_din; s_rd = mb_read; s_own = owner;
            end
            if (port ? cu_ack : dbg_ack) wrong_ack = 1;
            if (port ? dbg_ack : cu_ack) begin
                ack_c = c;
                rd = port ? dbg_rdata : cu_rdata;
                break;
            end
        end
        if (port) dbg_req = 0; else cu_req = 0;
        tick;
    endtask

    task automatic test_reset;
        logic [62:0] obs;
        rst = 1; cu_req = 1; cu_addr = 8'h33;
        tick; tick;
        obs = {state, cu_ack, dbg_ack, mb_read, mb_write, owner, mb_addr, mb_din, cu_rdata, dbg_rdata};
        checks++;
        if (obs !== 63'd0) begin errors++; $display("FAIL reset_state: got %h required 0", obs); end
        checks++;
        if ({l4_state, l4_mb_read, l4_cu_ack} !== 4'd0) begin
            errors++; $display("FAIL reset_state_lat4: got %h required 0", {l4_state, l4_mb_read, l4_cu_ack});
        end
        rst = 0; cu_req = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; model_last = 1;
        tick;
    endtask

    task automatic test_cu_read;
        int ack_c, stb_c; logic [7:0] sa; logic [15:0] sd, rd; bit srd, sown, wack, bstb;
        run_txn(0, 0, 8'h10, 16'h0, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
        checks++;
        if ({stb_c, sa, srd} !== {32'd1, 8'h10, 1'b1}) begin
            errors++; $display("FAIL cu_read_strobe: got cyc=%0d addr=%h rd=%0d required cyc=1 addr=10 rd=1", stb_c, sa, srd);
        end
        checks++;
        if (ack_c !== 3) begin errors++; $display("FAIL cu_read_ack_cycle: got %0d required 3", ack_c); end
        checks++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL cu_read_data: got %h required 1234", rd); end
        checks++;
        if (wack !== 1'b0) begin errors++; $display("FAIL cu_read_dbg_ack: got %0d required 0", wack); end
        exp_rdata[0] = 16'h1234; model_last = 0;
    endtask

    task automatic test_dbg_write;
        int ack_c, stb_c; logic [7:0] sa; logic [15:0] sd, rd; bit srd, sown, wack, bstb;
        run_txn(1, 1, 8'h05, 16'hBEEF, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
        checks++;
        if ({stb_c, sa, sd, srd, sown} !== {32'd1, 8'h05, 16'hBEEF, 1'b0, 1'b1}) begin
            errors++; $display("FAIL dbg_write_strobe: got cyc=%0d addr=%h din=%h rd=%0d own=%0d required 1/05/beef/0/1",
                               stb_c, sa, sd, srd, sown);
        end
        checks++;
        if (ack_c !== 2) begin errors++; $display("FAIL dbg_write_ack_cycle: got %0d required 2", ack_c); end
        checks++;
        if (rd !== 16'h0) begin errors++; $display("FAIL dbg_write_rdata: got %h required 0", rd); end
        ref_mem[5] = 16'hBEEF; model_last = 1;
        tick; tick;
        checks++;
        if ({mb_addr, mb_din, mb_write} !== {8'h05, 16'hBEEF, 1'b0}) begin
            errors++; $display("FAIL bus_hold: got addr=%h din=%h wr=%0d required 05/beef/0", mb_addr, mb_din, mb_write);
        end
    endtask

    task automatic test_random;
        int ack_c, stb_c, exp_ack; logic [7:0] sa, a; logic [15:0] sd, rd, d, exp_rd; bit srd, sown, wack, bstb, p, we;
        for (int i = 0; i < 24; i++) begin
            p = 1'($urandom); we = 1'($urandom); a = 8'($urandom_range(0, 15)); d = 16'($urandom);
            exp_ack = we ? 2 : 3;
            exp_rd  = we ? exp_rdata[p] : ref_rd(a);
            run_txn(p, we, a, d, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
            checks++;
            if ({ack_c, stb_c, sa, srd, sown, wack, bstb} !== {exp_ack, 32'd1, a, ~we, p, 1'b0, 1'b0}) begin
                errors++; $display("FAIL rand_txn%0d_timing: got ack=%0d stb=%0d addr=%h rd=%0d own=%0d xack=%0d both=%0d required ack=%0d stb=1 addr=%h rd=%0d own=%0d 0 0",
                                   i, ack_c, stb_c, sa, srd, sown, wack, bstb, exp_ack, a, ~we, p);
            end
            checks++;
            if (rd !== exp_rd || (we && sd !== d)) begin
                errors++; $display("FAIL rand_txn%0d_data: got rdata=%h din=%h required rdata=%h din=%h", i, rd, sd, exp_rd, d);
            end
            if (we) ref_mem[int'(a)] = d; else exp_rdata[p] = exp_rd;
            model_last = p;
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    task automatic test_back_to_back;
        int ack_at [4]; int n = 0; int c = 0;
        int ack_c, stb_c; logic [7:0] sa; logic [15:0] sd, rd; bit srd, sown, wack, bstb;
        cu_req = 1; cu_we = 1; cu_addr = 8'hC0; cu_wdata = 16'($urandom);
        while (n < 4 && c < 40) begin
            tick; c++;
            if (cu_ack) begin
                ack_at[n] = c; ref_mem[int'(cu_addr)] = cu_wdata; n++;
                if (n < 4) begin cu_addr = 8'hC0 + 8'(n); cu_wdata = 16'($urandom); end
                else cu_req = 0;
            end
        end
        cu_req = 0; model_last = 0;
        tick;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d acks required 4", n); end
        else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (ack_at[i] - ack_at[i-1] !== 3) begin
                    errors++; $display("FAIL b2b_interval%0d: got %0d required 3", i, ack_at[i] - ack_at[i-1]);
                end
            end
        end
        run_txn(1, 0, 8'hC3, 16'h0, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
        checks++;
        if (rd !== ref_rd(8'hC3)) begin errors++; $display("FAIL b2b_readback: got %h required %h", rd, ref_rd(8'hC3)); end
        exp_rdata[1] = ref_rd(8'hC3); model_last = 1;
    endtask

    task automatic test_round_robin;
        int n = 0; int c = 0; bit exp_p;
        cu_req = 1; cu_we = 0; cu_addr = 8'($urandom);
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'($urandom);
        while (n < 7 && c < 80) begin
            tick; c++;
            if (cu_ack || dbg_ack) begin
                exp_p = ~model_last;
                checks++;
                if ({cu_ack, dbg_ack} !== {~exp_p, exp_p}) begin
                    errors++; $display("FAIL rr_order%0d: got cu_ack=%0d dbg_ack=%0d required port %0d", n, cu_ack, dbg_ack, exp_p);
                end
                checks++;
                if (dbg_ack ? (dbg_rdata !== ref_rd(dbg_addr)) : (cu_rdata !== ref_rd(cu_addr))) begin
                    errors++; $display("FAIL rr_data%0d: got %h required %h", n, dbg_ack ? dbg_rdata : cu_rdata,
                                       dbg_ack ? ref_rd(dbg_addr) : ref_rd(cu_addr));
                end
                n++;
                if (dbg_ack) begin
                    exp_rdata[1] = ref_rd(dbg_addr); model_last = 1;
                    if (n >= 6) dbg_req = 0; else dbg_addr = 8'($urandom);
                end else begin
                    exp_rdata[0] = ref_rd(cu_addr); model_last = 0;
                    if (n >= 6) cu_req = 0; else cu_addr = 8'($urandom);
                end
            end
        end
        cu_req = 0; dbg_req = 0;
        tick;
        checks++;
        if (n !== 7) begin errors++; $display("FAIL rr_count: got %0d acks required 7", n); end
    endtask

    task automatic test_halt;
        int c = 0; int cu_halted = 0; int dacks = 0; int seq [$]; int exp_seq [5] = '{1, 1, 1, 0, 1};
        bit stb_seen = 0;
        int ack_c, stb_c; logic [7:0] sa, a; logic [15:0] sd, rd; bit srd, sown, wack, bstb;
        // Halt rising in the same cycle as a lone CU request blocks the grant.
        a = 8'($urandom);
        cu_req = 1; cu_we = 0; cu_addr = a; dbg_halt = 1;
        repeat (4) begin tick; if (mb_read || mb_write || state != 2'd0) stb_seen = 1; end
        checks++;
        if (stb_seen !== 1'b0) begin errors++; $display("FAIL halt_blocks_cu: got activity=1 required 0"); end
        dbg_halt = 0;
        run_txn(0, 0, a, 16'h0, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
        checks++;
        if ({ack_c, rd} !== {32'd3, ref_rd(a)}) begin
            errors++; $display("FAIL halt_release_cu: got ack=%0d data=%h required 3/%h", ack_c, rd, ref_rd(a));
        end
        exp_rdata[0] = ref_rd(a); model_last = 0;

        dbg_halt = 1;
        cu_req = 1; cu_we = 0; cu_addr = 8'($urandom);
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'($urandom);
        while (seq.size() < 5 && c < 80) begin
            tick; c++;
            if (cu_ack) begin
                if (dbg_halt) cu_halted++;
                seq.push_back(0);
                checks++;
                if (cu_rdata !== ref_rd(cu_addr)) begin
                    errors++; $display("FAIL halt_cu_data: got %h required %h", cu_rdata, ref_rd(cu_addr));
                end
                exp_rdata[0] = ref_rd(cu_addr); cu_req = 0;
            end
            if (dbg_ack) begin
                seq.push_back(1); dacks++;
                checks++;
                if (dbg_rdata !== ref_rd(dbg_addr)) begin
                    errors++; $display("FAIL halt_dbg_data: got %h required %h", dbg_rdata, ref_rd(dbg_addr));
                end
                exp_rdata[1] = ref_rd(dbg_addr);
                if (dacks == 3) dbg_halt = 0;
                if (dacks < 4) dbg_addr = 8'($urandom); else dbg_req = 0;
            end
        end
        cu_req = 0; dbg_req = 0; dbg_halt = 0; model_last = 1;
        tick;
        checks++;
        if (cu_halted !== 0) begin errors++; $display("FAIL halt_cu_ack: got %0d acks required 0", cu_halted); end
        checks++;
        if (seq.size() !== 5) begin errors++; $display("FAIL halt_count: got %0d acks required 5", seq.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seq[i] !== exp_seq[i]) begin
                    errors++; $display("FAIL halt_order%0d: got port %0d required %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_rst_mid;
        logic [62:0] obs; logic [7:0] a;
        int ack_c, stb_c; logic [7:0] sa; logic [15:0] sd, rd; bit srd, sown, wack, bstb;
        a = 8'($urandom);
        dbg_req = 1; dbg_we = 0; dbg_addr = a;
        tick; tick;
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL rst_mid_in_wait: got state %0d required 2", state); end
        rst = 1;
        tick;
        obs = {state, cu_ack, dbg_ack, mb_read, mb_write, owner, mb_addr, mb_din, cu_rdata, dbg_rdata};
        checks++;
        if (obs !== 63'd0) begin errors++; $display("FAIL rst_mid_state: got %h required 0", obs); end
        rst = 0; dbg_req = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; model_last = 1;
        tick;
        checks++;
        if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_late_ack: got 1 required 0"); end
        run_txn(1, 0, a, 16'h0, ack_c, stb_c, sa, sd, srd, sown, wack, bstb, rd);
        checks++;
        if ({ack_c, rd} !== {32'd3, ref_rd(a)}) begin
            errors++; $display("FAIL rst_mid_reissue: got ack=%0d data=%h required 3/%h", ack_c, rd, ref_rd(a));
        end
    endtask

    task automatic test_lat4;
        int ack_c = -1; int stb_c = -1; logic [7:0] a; logic [15:0] good, rd;
        a = 8'($urandom); good = 16'($urandom); rd = '0;
        l4_cu_req = 1; l4_cu_we = 0; l4_cu_addr = a;
        for (int c = 1; c <= 15; c++) begin
            tick;
            if (l4_mb_read && stb_c < 0 && l4_mb_addr == a) stb_c = c;
            if (l4_cu_ack) begin ack_c = c; rd = l4_cu_rdata; l4_cu_req = 0; break; end
            // Only the value present during cycle T+5 is the legitimate read data.
            l4_mb_data_out = (c == 5) ? good : (good ^ 16'(c * 16'h1111 + 1));
        end
        l4_cu_req = 0;
        tick;
        checks++;
        if (stb_c !== 1) begin errors++; $display("FAIL lat4_strobe: got cycle %0d required 1", stb_c); end
        checks++;
        if (ack_c !== 6) begin errors++; $display("FAIL lat4_ack_cycle: got %0d required 6", ack_c); end
        checks++;
        if (rd !== good) begin errors++; $display("FAIL lat4_data: got %h required %h", rd, good); end
    endtask

    initial begin
        test_reset;
        test_cu_read;
        test_dbg_write;
        test_random;
        test_back_to_back;
        test_round_robin;
        test_halt;
        test_rst_mid;
        test_lat4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Two-port arbiter and access sequencer for the shared memory bank (AW-bit address, DW-bit data). It multiplexes instruction/data accesses from the control unit (CU port) and a debug/loader port (DBG port) onto a single memory bank interface. Each access runs as a fixed req/ack transaction with registered memory-side outputs. Round-robin fairness applies, and a halt input gives the debug port exclusive ownership.

## Interface
Parameters:
- AW, 8, memory address width
- DW, 16, memory data width
- RD_LAT, 1, cycles from mb_read asserted to valid mb_data_out; legal range 1..4

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cu_req / cu_we  in  1 / 1  CU request; write when cu_we=1
- cu_addr / cu_wdata  in  AW / DW  CU address, write data
- cu_ack  out  1  one-cycle completion pulse to CU
- cu_rdata  out  DW  read data, valid while cu_ack=1 and held until the next CU read completes
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the CU set, for the DBG port
- dbg_halt  in  1  when high, cu_req is masked from arbitration
- mb_addr  out  AW  memory address
- mb_din  out  DW  memory write data
- mb_read / mb_write  out  1 / 1  memory strobes; one-cycle pulses, never both high
- mb_data_out  in  DW  memory read data
- owner  out  1  port of current or most recent grant (0=CU, 1=DBG)
- state  out  2  FSM state for diagnostics

## Operation
- FSM states: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
- **IDLE**
  - Sample effective requests: cu_eff = cu_req & ~dbg_halt, dbg_eff = dbg_req.
  - Only cu_eff: grant CU. Only dbg_eff: grant DBG.
  - Both: grant the port that is not in the `last` pointer. `last` resets to 1, so CU wins the first tie.
  - On grant: latch the port's we/addr/wdata into internal registers, update `last` and `owner`, go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - mb_addr and mb_din driven from the latched registers.
  - mb_write=1 if write, else mb_read=1.
  - Write: go to DONE. Read: go to WAIT and load the latency counter with RD_LAT-1.
- **WAIT**
  - If the counter is 0: capture mb_data_out into the granted port's rdata register and go to DONE. Otherwise decrement.
- **DONE**
  - Granted port's ack=1 for this cycle only, then go to IDLE.
- The requester holds req and its fields stable until it sees ack. It drops req in the cycle after ack.
  - If req is still high in the IDLE cycle following DONE, it is a new transaction. This allows back-to-back accesses.
- Write data is not returned: rdata is unchanged on write completion.
- dbg_halt affects new grants only. An in-flight CU transaction always completes and acks.
- mb_addr and mb_din hold their last values outside ISSUE. Only the strobes are qualified.

## Timing
- Reset values:
  - state=IDLE, cu_ack=dbg_ack=0, cu_rdata=dbg_rdata=0
  - mb_addr=0, mb_din=0, mb_read=mb_write=0
  - owner=0, last=1, counter=0
- Request seen in IDLE at cycle T:
  - Strobe at T+1.
  - Write ack at T+2. Read ack at T+2+RD_LAT.
  - mb_data_out is sampled at the end of cycle T+1+RD_LAT.
- Throughput, single requester: one write per 3 cycles; one read per 3+RD_LAT cycles.
- Simultaneous requests with round-robin: accesses strictly alternate CU, DBG, CU, ...
- rst mid-transaction: at the next edge go to IDLE with all outputs at reset values. No ack is issued and any pending strobe is dropped. Requesters must reissue.
- rst high and req high in the same cycle: no grant occurs.
- dbg_halt rising in the same IDLE cycle as cu_req: CU is not granted.

## Test plan
- Reset, then CU read of addr 0x10 (memory holds 0x1234), RD_LAT=1 -> mb_read pulse at T+1 with mb_addr=0x10, cu_ack at T+3, cu_rdata=0x1234, dbg_ack stays 0.
- DBG write of 0xBEEF to 0x05 -> mb_write pulse at T+1 with mb_addr=0x05, mb_din=0xBEEF, dbg_ack at T+2, dbg_rdata unchanged (0).
- Both ports requesting continuous reads for 6 transactions -> grant order CU, DBG, CU, DBG, CU, DBG; each ack lands on the correct port with the correct data.
- dbg_halt=1 with cu_req and dbg_req both high -> DBG granted repeatedly, cu_ack never asserts. Deassert dbg_halt -> CU granted next.
- RD_LAT=4 build, CU read -> ack at T+6, data sampled at the end of T+5; value driven earlier and changed before T+5 is not captured.
- rst pulsed during WAIT of a DBG read -> next cycle state=0, no dbg_ack, strobes 0; a reissued read then completes normally.
